// File: rtl/rtc_trim_prescaler_pkg.sv
// Shared constants for the RTC trim prescaler: default widths, reset divider
// and the encoding of the trim direction bit.
package rtc_trim_prescaler_pkg;

    localparam int DIV_W_DEF       = 16;
    localparam int WIN_W_DEF       = 10;
    localparam int DEFAULT_DIV_DEF = 32767;

    // Direction of the one-cycle correction applied to the trimmed seconds.
    localparam logic TRIM_SHORTEN  = 1'b0;
    localparam logic TRIM_LENGTHEN = 1'b1;

endpackage

// File: rtl/rtc_trim_shadow.sv
// Trim shadow: captures TRIMDIV/TRIMDEL/TRIMDIR on TRIMLOAD into a pending
// copy and hands it to the active trim registers only on a second boundary,
// so the divider never changes in the middle of a second.
module rtc_trim_shadow
    import rtc_trim_prescaler_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int WIN_W       = WIN_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             RTCCLK,
    input  logic             nRTCRST,
    input  logic             TRIMLOAD,
    input  logic [DIV_W-1:0] TRIMDIV,
    input  logic [WIN_W-1:0] TRIMDEL,
    input  logic             TRIMDIR,
    input  logic             boundary,
    output logic             apply,
    output logic [DIV_W-1:0] div_next,
    output logic [WIN_W-1:0] del_next,
    output logic             dir_next,
    output logic             TRIMPEND
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] shadow_div_reg;
    logic [WIN_W-1:0] shadow_del_reg;
    logic             shadow_dir_reg;
    logic             pend_reg;
    logic [DIV_W-1:0] div_reg;
    logic [WIN_W-1:0] del_reg;
    logic             dir_reg;

    // A pending capture is consumed on the boundary cycle; the old shadow is
    // used even if a new TRIMLOAD lands on that same cycle.
    assign apply    = boundary && pend_reg;
    assign TRIMPEND = pend_reg;

    // Active trim values seen by the divider for the upcoming second.
    always_comb begin
        div_next = apply ? shadow_div_reg : div_reg;
        del_next = apply ? shadow_del_reg : del_reg;
        dir_next = apply ? shadow_dir_reg : dir_reg;
    end

    // Shadow capture (latest load wins), pending flag and boundary hand-over.
    always_ff @(posedge RTCCLK) begin
        if (!nRTCRST) begin
            shadow_div_reg <= '0;
            shadow_del_reg <= '0;
            shadow_dir_reg <= TRIM_SHORTEN;
            pend_reg       <= 1'b0;
            div_reg        <= RESET_DIV;
            del_reg        <= '0;
            dir_reg        <= TRIM_SHORTEN;
        end else begin
            div_reg <= div_next;
            del_reg <= del_next;
            dir_reg <= dir_next;
            if (TRIMLOAD) begin
                shadow_div_reg <= TRIMDIV;
                shadow_del_reg <= TRIMDEL;
                shadow_dir_reg <= TRIMDIR;
                pend_reg       <= 1'b1;
            end else if (apply) begin
                pend_reg       <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rtc_trim_prescaler.sv
// RTC prescaler with digital trim: divides RTCCLK down to the 1Hz CLK1HZ
// that clocks the RTC counter. Each second lasts DIV+1 source cycles, except
// the first DEL seconds of every 2^WIN_W-second window, which are one cycle
// shorter or longer depending on the trim direction.
module rtc_trim_prescaler
    import rtc_trim_prescaler_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int WIN_W       = WIN_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             RTCCLK,
    input  logic             nRTCRST,
    input  logic             RTCEN,
    input  logic             TRIMLOAD,
    input  logic [DIV_W-1:0] TRIMDIV,
    input  logic [WIN_W-1:0] TRIMDEL,
    input  logic             TRIMDIR,
    output logic             TICK,
    output logic             CLK1HZ,
    output logic             TRIMPEND
);

    // One extra bit so DIV+2 never overflows.
    localparam int PW = DIV_W + 1;
    localparam logic [PW-1:0] RESET_CNT  = PW'(DEFAULT_DIV);
    localparam logic [PW-1:0] RESET_HALF = PW'((DEFAULT_DIV + 1) >> 1);

    // Length of a second in source cycles for a given window position.
    function automatic logic [PW-1:0] second_period(
        input logic [WIN_W-1:0] win,
        input logic [DIV_W-1:0] div,
        input logic [WIN_W-1:0] del,
        input logic             dir
    );
        logic [PW-1:0] p;
        if (win < del) begin
            p = (dir == TRIM_LENGTHEN) ? PW'(div) + PW'(2) : PW'(div);
        end else begin
            p = PW'(div) + PW'(1);
        end
        // A zero-length second is impossible; run at one cycle per second.
        if (p == '0) begin
            p = PW'(1);
        end
        return p;
    endfunction

    logic [PW-1:0]    pre_cnt_reg, pre_cnt_next;
    logic [PW-1:0]    half_reg, half_next;
    logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
    logic             tick_reg, tick_next;
    logic             clk1hz_reg, clk1hz_next;
    logic [PW-1:0]    period_next;
    logic             boundary;
    logic             apply;
    logic [DIV_W-1:0] div_next;
    logic [WIN_W-1:0] del_next;
    logic             dir_next;

    assign boundary = RTCEN && (pre_cnt_reg == '0);

    rtc_trim_shadow #(
        .DIV_W       (DIV_W),
        .WIN_W       (WIN_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow (
        .RTCCLK   (RTCCLK),
        .nRTCRST  (nRTCRST),
        .TRIMLOAD (TRIMLOAD),
        .TRIMDIV  (TRIMDIV),
        .TRIMDEL  (TRIMDEL),
        .TRIMDIR  (TRIMDIR),
        .boundary (boundary),
        .apply    (apply),
        .div_next (div_next),
        .del_next (del_next),
        .dir_next (dir_next),
        .TRIMPEND (TRIMPEND)
    );

    // Next-state of the down-counter, window position and output pulses.
    always_comb begin
        win_cnt_next = win_cnt_reg;
        pre_cnt_next = pre_cnt_reg;
        half_next    = half_reg;
        if (boundary) begin
            // A freshly applied trim restarts the window.
            win_cnt_next = apply ? '0 : win_cnt_reg + WIN_W'(1);
        end
        period_next = second_period(win_cnt_next, div_next, del_next, dir_next);
        if (boundary) begin
            pre_cnt_next = period_next - PW'(1);
            half_next    = period_next >> 1;
        end else if (RTCEN) begin
            pre_cnt_next = pre_cnt_reg - PW'(1);
        end
        // Counter value 0 is the last cycle of the second.
        tick_next   = (pre_cnt_next == '0);
        // High for the first ceil(P/2) cycles; half is zero only for P=1.
        clk1hz_next = (half_next != '0) && (pre_cnt_next >= half_next);
    end

    // Divider state: frozen while RTCEN is low, TICK suppressed meanwhile.
    always_ff @(posedge RTCCLK) begin
        if (!nRTCRST) begin
            pre_cnt_reg <= RESET_CNT;
            half_reg    <= RESET_HALF;
            win_cnt_reg <= '0;
            tick_reg    <= 1'b0;
            clk1hz_reg  <= 1'b0;
        end else if (RTCEN) begin
            pre_cnt_reg <= pre_cnt_next;
            half_reg    <= half_next;
            win_cnt_reg <= win_cnt_next;
            tick_reg    <= tick_next;
            clk1hz_reg  <= clk1hz_next;
        end else begin
            tick_reg    <= 1'b0;
        end
    end

    assign TICK   = tick_reg;
    assign CLK1HZ = clk1hz_reg;

endmodule

// File: tb/tb_rtc_trim_prescaler.sv
// Self-checking bench for rtc_trim_prescaler with DEFAULT_DIV=7, WIN_W=3.
module tb_rtc_trim_prescaler;

    localparam int DIV_W       = 8;
    localparam int WIN_W       = 3;
    localparam int DEFAULT_DIV = 7;
    localparam int WIN_N       = 1 << WIN_W;

    logic             RTCCLK   = 1'b0;
    logic             nRTCRST  = 1'b0;
    logic             RTCEN    = 1'b0;
    logic             TRIMLOAD = 1'b0;
    logic [DIV_W-1:0] TRIMDIV  = '0;
    logic [WIN_W-1:0] TRIMDEL  = '0;
    logic             TRIMDIR  = 1'b0;
    logic             TICK;
    logic             CLK1HZ;
    logic             TRIMPEND;

    int checks = 0;
    int errors = 0;

    always #5 RTCCLK = ~RTCCLK;

    rtc_trim_prescaler #(
        .DIV_W       (DIV_W),
        .WIN_W       (WIN_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .RTCCLK   (RTCCLK),
        .nRTCRST  (nRTCRST),
        .RTCEN    (RTCEN),
        .TRIMLOAD (TRIMLOAD),
        .TRIMDIV  (TRIMDIV),
        .TRIMDEL  (TRIMDEL),
        .TRIMDIR  (TRIMDIR),
        .TICK     (TICK),
        .CLK1HZ   (CLK1HZ),
        .TRIMPEND (TRIMPEND)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks each second as (period, cycle index within it) and the trim
    // state in plain integers.
    int m_div, m_del, m_dir, m_win, m_p, m_idx;
    int s_div, s_del, s_dir;
    bit m_pend, m_tick, m_clk, m_applied;
    bit m_valid = 1'b0;

    function automatic int spec_period(input int win, input int div, input int del, input int dir);
        int p;
        if (win < del) p = (dir != 0) ? div + 2 : div;
        else           p = div + 1;
        if (p == 0) p = 1;
        return p;
    endfunction

    initial forever begin
        @(posedge RTCCLK);
        if (!nRTCRST) begin
            m_div = DEFAULT_DIV; m_del = 0; m_dir = 0; m_win = 0;
            m_p = spec_period(0, DEFAULT_DIV, 0, 0); m_idx = 0;
            s_div = 0; s_del = 0; s_dir = 0;
            m_pend = 0; m_tick = 0; m_clk = 0; m_valid = 1;
        end else begin
            m_applied = 0;
            if (RTCEN) begin
                if (m_idx == m_p - 1) begin
                    if (m_pend) begin
                        m_div = s_div; m_del = s_del; m_dir = s_dir;
                        m_win = 0; m_applied = 1;
                    end else begin
                        m_win = (m_win + 1) % WIN_N;
                    end
                    m_p   = spec_period(m_win, m_div, m_del, m_dir);
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
                m_tick = (m_idx == m_p - 1);
                m_clk  = (m_p >= 2) && (m_idx < (m_p + 1) / 2);
            end else begin
                m_tick = 0;
            end
            if (TRIMLOAD) begin
                s_div = int'(TRIMDIV); s_del = int'(TRIMDEL); s_dir = int'(TRIMDIR);
                m_pend = 1;
            end else if (m_applied) begin
                m_pend = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge RTCCLK);
        if (m_valid) begin
            check("tick",     TICK,     m_tick);
            check("clk1hz",   CLK1HZ,   m_clk);
            check("trimpend", TRIMPEND, m_pend);
        end
    end

    // ---------------- directed stimulus ----------------
    int exp2_p[8] = '{4, 4, 5, 5, 5, 5, 5, 5};
    int exp2_h[8] = '{2, 2, 3, 3, 3, 3, 3, 3};
    int exp3_p[8] = '{6, 6, 6, 5, 5, 5, 5, 5};

    task automatic load(input int div, input int del, input int dir);
        TRIMDIV  = DIV_W'(div);
        TRIMDEL  = WIN_W'(del);
        TRIMDIR  = dir[0];
        TRIMLOAD = 1'b1;
        $display("load div=%0d del=%0d dir=%0d", div, del, dir);
        @(negedge RTCCLK);
        TRIMLOAD = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge RTCCLK);
            n++;
        end while (TICK !== 1'b1 && n < 200);
        check("wait_tick", TICK, 1);
    endtask

    // Measures one second starting at a TICK cycle, ending at the next TICK.
    task automatic measure(input string name, input int exp_p, input int exp_hi);
        int per = 0;
        int hi  = 0;
        do begin
            @(negedge RTCCLK);
            per++;
            if (CLK1HZ === 1'b1) hi++;
        end while (TICK !== 1'b1 && per < 200);
        $display("second %s: period=%0d high=%0d", name, per, hi);
        check({name, "_period"}, per, exp_p);
        check({name, "_high"}, hi, exp_hi);
    endtask

    initial begin
        int cnt;
        // 1: reset and default divider
        repeat (2) @(negedge RTCCLK);
        check("rst_tick", TICK, 0);
        check("rst_clk1hz", CLK1HZ, 0);
        check("rst_pend", TRIMPEND, 0);
        nRTCRST = 1'b1;
        RTCEN   = 1'b1;
        wait_tick();
        measure("s1a", 8, 4);
        measure("s1b", 8, 4);

        // 2: shorten first two seconds of each window
        @(negedge RTCCLK);
        check("s1_rise_after_tick", CLK1HZ, 1);
        load(4, 2, 0);
        check("s2_pend", TRIMPEND, 1);
        wait_tick();
        for (int i = 0; i < 8; i++) measure($sformatf("s2_%0d", i), exp2_p[i], exp2_h[i]);
        check("s2_pend_clear", TRIMPEND, 0);

        // 3: lengthen first three seconds of each window
        @(negedge RTCCLK);
        load(4, 3, 1);
        check("s3_pend", TRIMPEND, 1);
        wait_tick();
        for (int i = 0; i < 8; i++) measure($sformatf("s3_%0d", i), exp3_p[i], 3);

        // 4: two loads in one second, latest wins
        @(negedge RTCCLK);
        load(2, 0, 0);
        load(9, 0, 0);
        check("s4_pend", TRIMPEND, 1);
        wait_tick();
        measure("s4", 10, 5);
        check("s4_pend_clear", TRIMPEND, 0);

        // 5: DIV=0 shorten -> one-cycle seconds
        @(negedge RTCCLK);
        load(0, 7, 0);
        wait_tick();
        for (int i = 0; i < 12; i++) begin
            @(negedge RTCCLK);
            check("s5_tick_held", TICK, 1);
            check("s5_clk1hz_low", CLK1HZ, 0);
        end

        // 6: freeze mid-second, then reset mid-second
        load(5, 0, 0);
        wait_tick();
        cnt = 0;
        repeat (2) begin @(negedge RTCCLK); cnt++; end
        RTCEN = 1'b0;
        repeat (5) begin
            @(negedge RTCCLK);
            cnt++;
            check("s6_frozen_tick", TICK, 0);
            check("s6_frozen_clk1hz", CLK1HZ, 1);
        end
        RTCEN = 1'b1;
        do begin
            @(negedge RTCCLK);
            cnt++;
        end while (TICK !== 1'b1 && cnt < 200);
        $display("second s6_freeze: period=%0d", cnt);
        check("s6_freeze_period", cnt, 11);
        @(negedge RTCCLK);
        load(5, 0, 0);
        @(negedge RTCCLK);
        nRTCRST = 1'b0;
        @(negedge RTCCLK);
        check("s6_rst_tick", TICK, 0);
        check("s6_rst_clk1hz", CLK1HZ, 0);
        check("s6_rst_pend", TRIMPEND, 0);
        nRTCRST = 1'b1;
        wait_tick();
        measure("s6_after_reset", 8, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
